phase_diff_avg: RTL and testbench



---
 rtl/phase_diff_avg_if.sv | 34 +++
 rtl/phase_diff_avg.sv | 168 ++++++++++++++++
 tb/tb_phase_diff_avg.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_diff_avg_if.sv
// Bus bundle for phase_diff_avg: phase snapshot strobe in, averaged
// baseline differences plus status out.
//
// Handshake: phase_valid is a one-cycle strobe with no ready. The phase
// words must be stable in the strobed cycle. A strobe is accepted only
// when busy is low. A strobe seen while busy is dropped and reported by a
// one-cycle overrun pulse on the next cycle. out_valid is a one-cycle pulse
// and the diff words are updated in that same cycle. They then hold their
// values until the next pulse. state_dbg mirrors the internal FSM state.
interface phase_diff_avg_if;
  logic               phase_valid;
  logic signed [15:0] phase1;
  logic signed [15:0] phase2;
  logic signed [15:0] phase3;
  logic signed [15:0] phase4;
  logic               clear;
  logic signed [15:0] diff12;
  logic signed [15:0] diff13;
  logic signed [15:0] diff14;
  logic               out_valid;
  logic               busy;
  logic               overrun;
  logic [2:0]         state_dbg;

  modport master (
    output phase_valid, phase1, phase2, phase3, phase4, clear,
    input  diff12, diff13, diff14, out_valid, busy, overrun, state_dbg
  );

  modport slave (
    input  phase_valid, phase1, phase2, phase3, phase4, clear,
    output diff12, diff13, diff14, out_valid, busy, overrun, state_dbg
  );
endinterface

// File: rtl/phase_diff_avg.sv
// Averaged baseline phase differences (1-2, 1-3, 1-4) for four hydrophone
// phases in 9Q7 degrees. A single subtract/wrap unit is shared across the
// three baselines over three cycles. 2^LOG2N difference sets are summed,
// and the floor mean is published with a one-cycle valid strobe.
module phase_diff_avg #(
  parameter int LOG2N = 2
) (
  input logic             clock,
  input logic             reset,
  phase_diff_avg_if.slave bus
);

  localparam int ACC_W = 16 + LOG2N;
  localparam logic [LOG2N:0] COUNT_MAX = (LOG2N + 1)'(1) << LOG2N;
  localparam logic [LOG2N:0] COUNT_ONE = (LOG2N + 1)'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    D12  = 3'd1,
    D13  = 3'd2,
    D14  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state;

  logic signed [15:0]      snap1;
  logic signed [15:0]      snap2;
  logic signed [15:0]      snap3;
  logic signed [15:0]      snap4;
  logic signed [ACC_W-1:0] acc12;
  logic signed [ACC_W-1:0] acc13;
  logic signed [ACC_W-1:0] acc14;
  logic [LOG2N:0]          count;
  logic [LOG2N:0]          count_inc;

  logic signed [15:0]      diff12_q;
  logic signed [15:0]      diff13_q;
  logic signed [15:0]      diff14_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    overrun_q;

  // Shared subtract/wrap datapath signals
  logic signed [15:0]      sub_b;
  logic signed [16:0]      raw;
  logic signed [15:0]      wrapped;
  logic signed [ACC_W-1:0] wrapped_ext;

  // Pick the baseline partner for the difference being formed this cycle
  always_comb begin
    sub_b = snap2;
    case (state)
      D13:     sub_b = snap3;
      D14:     sub_b = snap4;
      default: sub_b = snap2;
    endcase
  end

  assign raw = 17'(snap1) - 17'(sub_b);

  // Fold the raw difference back into [-180, +180) degrees
  always_comb begin
    wrapped = 16'(raw);
    if (raw >= 17'sd23040) begin
      wrapped = 16'(raw - 17'sd46080);
    end else if (raw < -17'sd23040) begin
      wrapped = 16'(raw + 17'sd46080);
    end
  end

  assign wrapped_ext = ACC_W'(wrapped);
  assign count_inc   = count + COUNT_ONE;

  // Sequencer: snapshot, three accumulate steps, optional publish step
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      snap1       <= '0;
      snap2       <= '0;
      snap3       <= '0;
      snap4       <= '0;
      acc12       <= '0;
      acc13       <= '0;
      acc14       <= '0;
      count       <= '0;
      diff12_q    <= '0;
      diff13_q    <= '0;
      diff14_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      // A strobe that lands while the sequencer is occupied is lost
      overrun_q   <= bus.phase_valid && (state != IDLE) && !bus.clear;
      if (bus.clear) begin
        state  <= IDLE;
        snap1  <= '0;
        snap2  <= '0;
        snap3  <= '0;
        snap4  <= '0;
        acc12  <= '0;
        acc13  <= '0;
        acc14  <= '0;
        count  <= '0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.phase_valid) begin
              snap1  <= bus.phase1;
              snap2  <= bus.phase2;
              snap3  <= bus.phase3;
              snap4  <= bus.phase4;
              state  <= D12;
              busy_q <= 1'b1;
            end
          end
          D12: begin
            acc12 <= acc12 + wrapped_ext;
            state <= D13;
          end
          D13: begin
            acc13 <= acc13 + wrapped_ext;
            state <= D14;
          end
          D14: begin
            acc14 <= acc14 + wrapped_ext;
            count <= count_inc;
            if (count_inc == COUNT_MAX) begin
              state <= DONE;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
          DONE: begin
            // Arithmetic shift gives the floor of the mean
            diff12_q    <= 16'(acc12 >>> LOG2N);
            diff13_q    <= 16'(acc13 >>> LOG2N);
            diff14_q    <= 16'(acc14 >>> LOG2N);
            out_valid_q <= 1'b1;
            acc12       <= '0;
            acc13       <= '0;
            acc14       <= '0;
            count       <= '0;
            state       <= IDLE;
            busy_q      <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.diff12    = diff12_q;
  assign bus.diff13    = diff13_q;
  assign bus.diff14    = diff14_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_phase_diff_avg.sv
// Bench for phase_diff_avg: one instance averaging 4 sets, one passing
// every set through. Expected means come from a sample-list reference model.
module tb_phase_diff_avg;

  logic clock;
  logic reset;

  phase_diff_avg_if if0 ();
  phase_diff_avg_if if2 ();

  phase_diff_avg #(.LOG2N(0)) u_dut0 (.clock(clock), .reset(reset), .bus(if0));
  phase_diff_avg #(.LOG2N(2)) u_dut2 (.clock(clock), .reset(reset), .bus(if2));

  int errors = 0;
  int checks = 0;

  // Reference model: running sums of wrapped differences per instance
  int sum_m [2][3];
  int cnt_m [2];
  logic [47:0] exp_q0[$];
  logic [47:0] exp_q1[$];

  // Clock generation
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap_ref(int a, int b);
    int d;
    d = a - b;
    if (d >= 23040) d = d - 46080;
    else if (d < -23040) d = d + 46080;
    return d;
  endfunction

  function automatic int floor_div(int s, int n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  task automatic model_clear(input int k);
    for (int j = 0; j < 3; j++) sum_m[k][j] = 0;
    cnt_m[k] = 0;
  endtask

  task automatic model_add(input int k, input int p1, input int p2, input int p3,
                           input int p4, output logic fin);
    int n;
    logic [47:0] e;
    n = (k == 0) ? 1 : 4;
    sum_m[k][0] += wrap_ref(p1, p2);
    sum_m[k][1] += wrap_ref(p1, p3);
    sum_m[k][2] += wrap_ref(p1, p4);
    cnt_m[k]++;
    fin = 1'b0;
    if (cnt_m[k] == n) begin
      e = {16'(floor_div(sum_m[k][0], n)), 16'(floor_div(sum_m[k][1], n)),
           16'(floor_div(sum_m[k][2], n))};
      if (k == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
      model_clear(k);
      fin = 1'b1;
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int k, input logic pv, input logic clr, input int p1,
                       input int p2, input int p3, input int p4);
    if (k == 0) begin
      if0.phase_valid = pv; if0.clear = clr;
      if0.phase1 = 16'(p1); if0.phase2 = 16'(p2); if0.phase3 = 16'(p3); if0.phase4 = 16'(p4);
    end else begin
      if2.phase_valid = pv; if2.clear = clr;
      if2.phase1 = 16'(p1); if2.phase2 = 16'(p2); if2.phase3 = 16'(p3); if2.phase4 = 16'(p4);
    end
  endtask

  task automatic get(input int k, output logic ov, output logic bz, output logic orun,
                     output logic signed [15:0] d12, output logic signed [15:0] d13,
                     output logic signed [15:0] d14);
    if (k == 0) begin
      ov = if0.out_valid; bz = if0.busy; orun = if0.overrun;
      d12 = if0.diff12; d13 = if0.diff13; d14 = if0.diff14;
    end else begin
      ov = if2.out_valid; bz = if2.busy; orun = if2.overrun;
      d12 = if2.diff12; d13 = if2.diff13; d14 = if2.diff14;
    end
  endtask

  function automatic int rnd_phase();
    return int'($urandom_range(46080, 0)) - 23040;
  endfunction

  // One accepted sample; returns in the earliest cycle a new strobe may go in
  task automatic send(input int k, input int p1, input int p2, input int p3, input int p4);
    logic fin, ov, bz, orun;
    logic signed [15:0] a, b, c;
    model_add(k, p1, p2, p3, p4, fin);
    drive(k, 1'b1, 1'b0, p1, p2, p3, p4);
    tick;
    drive(k, 1'b0, 1'b0, rnd_phase(), rnd_phase(), rnd_phase(), rnd_phase());
    for (int cy = 1; cy <= 3; cy++) begin
      get(k, ov, bz, orun, a, b, c);
      check("busy during diff steps", bz, 1);
      check("out_valid during diff steps", ov, 0);
      check("overrun during diff steps", orun, 0);
      tick;
    end
    get(k, ov, bz, orun, a, b, c);
    check("busy in cycle 4", bz, fin);
    check("out_valid in cycle 4", ov, 0);
    if (fin) begin
      tick;
      get(k, ov, bz, orun, a, b, c);
      check("out_valid in cycle 5", ov, 1);
      check("busy in cycle 5", bz, 0);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the next expected mean
  always @(negedge clock) begin
    logic [47:0] e;
    if (if0.out_valid === 1'b1) begin
      check("dut0 out_valid expected", 1, exp_q0.size() > 0);
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        check("dut0 diff12", if0.diff12, $signed(e[47:32]));
        check("dut0 diff13", if0.diff13, $signed(e[31:16]));
        check("dut0 diff14", if0.diff14, $signed(e[15:0]));
      end
    end
    if (if2.out_valid === 1'b1) begin
      check("dut2 out_valid expected", 1, exp_q1.size() > 0);
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        check("dut2 diff12", if2.diff12, $signed(e[47:32]));
        check("dut2 diff13", if2.diff13, $signed(e[31:16]));
        check("dut2 diff14", if2.diff14, $signed(e[15:0]));
      end
    end
  end

  // Directed sequence
  initial begin
    logic ov, bz, orun, fin;
    logic signed [15:0] a, b, c;
    model_clear(0);
    model_clear(1);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 0, 0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0, 0, 0);

    // Asynchronous reset between edges
    #3 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      get(k, ov, bz, orun, a, b, c);
      check("reset out_valid", ov, 0);
      check("reset busy", bz, 0);
      check("reset overrun", orun, 0);
      check("reset diff12", a, 0);
      check("reset diff13", b, 0);
      check("reset diff14", c, 0);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      get(1, ov, bz, orun, a, b, c);
      check("idle after reset out_valid", ov, 0);
      check("idle after reset busy", bz, 0);
      check("idle after reset diff12", a, 0);
    end

    // Basic average, back-to-back at the earliest legal spacing
    for (int i = 0; i < 4; i++) send(1, 1280, 640, -2560, 11520);
    check("basic diff12", if2.diff12, 640);
    check("basic diff13", if2.diff13, 3840);
    check("basic diff14", if2.diff14, -10240);

    // Wrap cases with pass-through averaging
    send(0, 21760, -21760, 0, 0);
    check("wrap +ovf diff12", if0.diff12, -2560);
    send(0, -21760, 0, 0, 21760);
    check("wrap -ovf diff14", if0.diff14, 2560);
    send(0, 11520, 0, -11520, 0);
    check("wrap raw +180 diff13", if0.diff13, -23040);
    send(0, -11520, 0, 11520, 0);
    check("wrap raw -180 diff13", if0.diff13, -23040);

    // Floor rounding of negative and small positive sums
    send(1, -1, 0, -1, -1);
    for (int i = 0; i < 3; i++) send(1, 0, 0, 0, 0);
    check("floor -1/4", if2.diff12, -1);
    send(1, 3, 0, 3, 3);
    for (int i = 0; i < 3; i++) send(1, 0, 0, 0, 0);
    check("floor 3/4", if2.diff12, 0);

    // Overrun: second strobe two cycles after the first is dropped
    model_add(1, 2000, 1000, 500, -4000, fin);
    drive(1, 1'b1, 1'b0, 2000, 1000, 500, -4000);
    tick;
    drive(1, 1'b0, 1'b0, 0, 0, 0, 0);
    tick;
    get(1, ov, bz, orun, a, b, c);
    check("overrun before extra strobe", orun, 0);
    drive(1, 1'b1, 1'b0, 9999, -9999, 7777, -7777);
    tick;
    drive(1, 1'b0, 1'b0, 0, 0, 0, 0);
    get(1, ov, bz, orun, a, b, c);
    check("overrun pulse cycle 3", orun, 1);
    tick;
    get(1, ov, bz, orun, a, b, c);
    check("overrun cleared cycle 4", orun, 0);
    check("busy after dropped strobe", bz, 0);
    send(1, 2000, 1000, 500, -4000);
    send(1, -3000, 4000, 22000, -22000);
    send(1, 100, 200, 300, 400);

    // Clear and strobe together in IDLE: clear wins
    drive(1, 1'b1, 1'b1, 5000, 1, 2, 3);
    tick;
    drive(1, 1'b0, 1'b0, 0, 0, 0, 0);
    get(1, ov, bz, orun, a, b, c);
    check("clear beats strobe busy", bz, 0);
    check("clear beats strobe overrun", orun, 0);
    tick;

    // Randomized traffic on both instances
    for (int i = 0; i < 8; i++) begin
      send(1, rnd_phase(), rnd_phase(), rnd_phase(), rnd_phase());
      repeat ($urandom_range(2, 0)) tick;
    end
    for (int i = 0; i < 6; i++) begin
      send(0, rnd_phase(), rnd_phase(), rnd_phase(), rnd_phase());
      repeat ($urandom_range(2, 0)) tick;
    end

    // Reset during D13 of the third sample
    send(1, 7000, -100, 300, 9000);
    send(1, -7000, 100, -300, 6000);
    drive(1, 1'b1, 1'b0, 1234, 2345, 3456, 4567);
    tick;
    drive(1, 1'b0, 1'b0, 0, 0, 0, 0);
    tick;
    get(1, ov, bz, orun, a, b, c);
    check("busy in D13 before reset", bz, 1);
    #2 reset = 1'b1;
    #1;
    get(1, ov, bz, orun, a, b, c);
    check("mid reset busy", bz, 0);
    check("mid reset diff12", a, 0);
    check("mid reset diff13", b, 0);
    check("mid reset diff14", c, 0);
    check("mid reset dut0 diff12", if0.diff12, 0);
    model_clear(0);
    model_clear(1);
    @(negedge clock);
    reset = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) send(1, 5000, 5000, 5000, 5000);
    check("after reset equal diff12", if2.diff12, 0);
    check("after reset equal diff14", if2.diff14, 0);

    // Clear during D13 of the third sample; outputs hold
    for (int i = 0; i < 4; i++) send(1, 1280, 640, -2560, 11520);
    send(1, 3000, 0, 0, 0);
    send(1, 3000, 0, 0, 0);
    drive(1, 1'b1, 1'b0, 3000, 0, 0, 0);
    tick;
    drive(1, 1'b0, 1'b0, 0, 0, 0, 0);
    tick;
    drive(1, 1'b0, 1'b1, 0, 0, 0, 0);
    tick;
    drive(1, 1'b0, 1'b0, 0, 0, 0, 0);
    model_clear(1);
    get(1, ov, bz, orun, a, b, c);
    check("clear busy", bz, 0);
    check("clear out_valid", ov, 0);
    check("clear hold diff12", a, 640);
    check("clear hold diff13", b, 3840);
    check("clear hold diff14", c, -10240);
    for (int i = 0; i < 3; i++) begin
      send(1, 2560, 0, 0, 0);
      check("hold until next out_valid", if2.diff12, 640);
    end
    send(1, 2560, 0, 0, 0);
    check("after clear new diff12", if2.diff12, 2560);

    repeat (10) tick;
    check("dut0 expected queue drained", exp_q0.size(), 0);
    check("dut2 expected queue drained", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
